// File: rtl/serial_bit_source.sv
// Parallel-to-serial word source: accepts words over valid/ready and shifts them
// out MSB-first on x, with an optional fixed idle gap after each word.
module serial_bit_source #(
  parameter int WIDTH = 8,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             frame_start,
  output logic             busy
);
  localparam int             BW       = $clog2(WIDTH);
  localparam logic [BW-1:0]  BIT_LAST = BW'(WIDTH - 1);
  localparam logic [3:0]     GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   sr_q;
  logic [BW-1:0]      bit_cnt_q;
  logic [3:0]         gap_cnt_q;
  logic               x_q, x_valid_q, frame_start_q, busy_q;
  logic               xfer;

  // Ready only at points where the next cycle is free for a new MSB.
  assign din_ready = reset &&
                     ((state_q == S_IDLE) ||
                      (state_q == S_SHIFT && bit_cnt_q == BIT_LAST && GAP == 0) ||
                      (state_q == S_GAP && gap_cnt_q == GAP_LAST));
  assign xfer = din_valid && din_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      sr_q          <= '0;
      bit_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      x_q           <= 1'b0;
      x_valid_q     <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      if (xfer) begin
        state_q       <= S_SHIFT;
        sr_q          <= din;
        bit_cnt_q     <= '0;
        x_q           <= din[WIDTH-1];
        x_valid_q     <= 1'b1;
        frame_start_q <= 1'b1;
        busy_q        <= 1'b1;
      end else begin
        case (state_q)
          S_SHIFT: begin
            if (bit_cnt_q != BIT_LAST) begin
              sr_q      <= sr_q << 1;
              bit_cnt_q <= bit_cnt_q + BW'(1);
              x_q       <= sr_q[WIDTH-2];
            end else if (GAP > 0) begin
              state_q   <= S_GAP;
              gap_cnt_q <= '0;
              x_q       <= 1'b0;
              x_valid_q <= 1'b0;
            end else begin
              state_q   <= S_IDLE;
              x_q       <= 1'b0;
              x_valid_q <= 1'b0;
              busy_q    <= 1'b0;
            end
          end
          S_GAP: begin
            if (gap_cnt_q != GAP_LAST) begin
              gap_cnt_q <= gap_cnt_q + 4'd1;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign x           = x_q;
  assign x_valid     = x_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;
endmodule

// File: doc/serial_bit_source.md
# serial_bit_source

Upstream stage of the serial pattern detectors. Accepts parallel words over a valid/ready handshake and shifts each word out MSB-first, one bit per clock, on the single-bit `x` line that feeds a detector such as the 1011 detector. An optional programmable idle gap can be inserted between words. `x_valid` qualifies every shifted bit.

## Interface
- `WIDTH`, 8: bits per word; legal range 2..32.
- `GAP`, 0: idle cycles inserted after each word before the next word's first bit; legal range 0..15.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `din`  in  WIDTH  parallel word; bit WIDTH-1 is transmitted first.
- `din_valid`  in  1  producer has a word on `din`.
- `din_ready`  out  1  block will capture `din` at this edge; combinational.
- `x`  out  1  serial bit to the detector; registered.
- `x_valid`  out  1  `x` carries a data bit this cycle; registered.
- `frame_start`  out  1  one-cycle pulse aligned with a word's first bit (MSB); registered.
- `busy`  out  1  high in SHIFT or GAP; registered.

## Operation
- States:
  - IDLE: nothing to send.
  - SHIFT: presenting bits; `bit_cnt` runs 0..WIDTH-1.
  - GAP: idle spacing; `gap_cnt` runs 0..GAP-1.
- Transfer occurs at a rising edge where `din_valid && din_ready`. The word is loaded into the shift register and `bit_cnt` is cleared.
- `din_ready` is high under exactly these conditions, and low otherwise:
  - state is IDLE; or
  - state is SHIFT, `bit_cnt == WIDTH-1` and GAP == 0; or
  - state is GAP and `gap_cnt == GAP-1`.
- `din_ready` is forced low while `reset` is low.
- IDLE → SHIFT on a transfer.
- SHIFT, while `bit_cnt < WIDTH-1`: shift left one bit, increment `bit_cnt`.
- SHIFT at `bit_cnt == WIDTH-1`:
  - GAP > 0: go to GAP.
  - GAP == 0 with a transfer: stay in SHIFT and load the new word. The stream stays contiguous.
  - GAP == 0 without a transfer: go to IDLE.
- GAP at `gap_cnt == GAP-1`: go to SHIFT on a transfer, otherwise go to IDLE.
- Output values by state:
  - In SHIFT: `x` = current MSB of the shift register, `x_valid` = 1.
  - In IDLE and GAP: `x` = 0, `x_valid` = 0.
  - `frame_start` = 1 only in the first SHIFT cycle of each word.
- `din` is sampled only at the transfer edge. Later changes on `din` have no effect on the word in flight.
- `din_valid` while `din_ready` is low is ignored. The producer holds its word until accepted; no data is lost or duplicated.

## Timing
- Reset (`reset` low), applied immediately and asynchronously:
  - state = IDLE, counters = 0, shift register = 0.
  - `x` = 0, `x_valid` = 0, `frame_start` = 0, `busy` = 0.
- Reset release: first transfer possible at the first rising edge after `reset` goes high.
- Latency: the MSB appears on `x` (with `x_valid` = 1 and `frame_start` = 1) in the cycle immediately after the transfer edge.
- A word occupies exactly WIDTH cycles of `x_valid` = 1.
- Word-to-word spacing with continuous `din_valid`:
  - GAP == 0: exactly WIDTH cycles from first bit to first bit; no `x_valid` holes.
  - GAP > 0: exactly WIDTH+GAP cycles from first bit to first bit.
- Reset asserted mid-word or mid-gap: the partial word is discarded and outputs go to reset values at once. After release, the next word starts from its MSB.
- `busy` equals `x_valid || (state == GAP)`, registered together with state.

## Test plan
- WIDTH=8, GAP=0; reset, then one transfer of 8'b1011_0000 → over the next 8 cycles `x` = 1,0,1,1,0,0,0,0 with `x_valid` = 1; `frame_start` only on cycle 1; then IDLE, `x_valid` = 0, `din_ready` = 1.
- WIDTH=4, GAP=0; back-to-back words 4'b1011 and 4'b0110 with `din_valid` held high → 8 contiguous valid bits 1,0,1,1,0,1,1,0; `frame_start` on bits 1 and 5; `din_ready` high only on the IDLE accept and the last-bit cycle.
- WIDTH=4, GAP=2; two queued words → 4 valid bits, then 2 cycles of `x` = 0 / `x_valid` = 0, then the second word; first-bit spacing is 6 cycles.
- `din_valid` asserted with 4'b1111 during a word in flight → `din_ready` = 0 and no capture; the word is accepted only at the permitted edge and its bits are unchanged.
- Reset pulled low at bit 3 of 8'b1011_1011 → `x`, `x_valid`, `busy` drop to 0 immediately; after release, a transfer of 8'b1011_0000 is shifted from its MSB with no residue of the old word.
- `din` changed the cycle after a transfer of 4'b1011 → output stays 1,0,1,1.
